// File: rtl/multi_cycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_cycle_controller: Moore FSM sequencing a multi-cycle RV32I datapath |
// | Optional macro ILLEGAL_TRAP_EN adds the TRAP hold state and illegal_op.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module multi_cycle_controller #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [2:0] imm_src,
  output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_READ = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WRITE= 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;

  localparam logic [2:0] c_alu_add  = 3'b000;
  localparam logic [2:0] c_alu_sub  = 3'b001;
  localparam logic [2:0] c_alu_and  = 3'b010;
  localparam logic [2:0] c_alu_or   = 3'b011;
  localparam logic [2:0] c_alu_xor  = 3'b100;
  localparam logic [2:0] c_alu_slt  = 3'b101;
  localparam logic [2:0] c_alu_sltu = 3'b110;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;
  localparam logic [2:0] c_imm_u = 3'b100;

  localparam logic [3:0] c_lat = 4'(MEM_LAT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_lat_done;

  assign w_lat_done = (r_cnt == c_lat);
  assign state      = r_state;

  function automatic logic [2:0] alu_for_funct3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? c_alu_sub : c_alu_add;
      3'b100:  return c_alu_xor;
      3'b110:  return c_alu_or;
      3'b111:  return c_alu_and;
      3'b010:  return c_alu_slt;
      3'b011:  return c_alu_sltu;
      default: return c_alu_add;
    endcase
  endfunction

  // Wait counter restarts on every state change so each memory state gets MEM_LAT+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = c_alu_add;
    imm_src    = c_imm_i;
`ifdef ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (w_lat_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == c_op_jal) ? c_imm_j : c_imm_b;
        case (op)
          c_op_load, c_op_store: w_next = S_MEM_ADR;
          c_op_r:                w_next = S_EXEC_R;
          c_op_i:                w_next = S_EXEC_I;
          c_op_branch:           w_next = S_BRANCH;
          c_op_jal:              w_next = S_JAL;
          c_op_jalr:             w_next = S_JALR_ADR;
          c_op_lui:              w_next = S_LUI;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == c_op_store) ? c_imm_s : c_imm_i;
        w_next    = (op == c_op_store) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        if (w_lat_done) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (w_lat_done) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_for_funct3(funct3, funct7_5);
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_for_funct3(funct3, 1'b0);
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        // blt/bge compare via slt: a taken blt yields a nonzero result.
        alu_src_a = 2'b10;
        alu_ctrl  = funct3[2] ? c_alu_slt : c_alu_sub;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          3'b100:  pc_write = ~zero;
          3'b101:  pc_write = zero;
          default: pc_write = 1'b0;
        endcase
        w_next = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = S_JAL;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = c_imm_u;
        w_next    = S_ALU_WB;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
`endif
        w_next = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = c_alu_add;
      imm_src    = c_imm_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// Bench for multi_cycle_controller: per-cycle vector table on a MEM_LAT=0 instance,
// plus hand sequences for reset, slow memory (MEM_LAT=2) and illegal opcodes.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'h23;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_ctrl, imm_src;
  logic [3:0] state;
  logic       pc_write2, adr_src2, mem_write2, ir_write2, reg_write2;
  logic [1:0] result_src2, alu_src_a2, alu_src_b2;
  logic [2:0] alu_ctrl2, imm_src2;
  logic [3:0] state2;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op, illegal_op2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src), .state(state)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  multi_cycle_controller #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
    .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .alu_ctrl(alu_ctrl2), .imm_src(imm_src2), .state(state2)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op2)
`endif
  );

  logic [16:0] outs0, outs2;
  assign outs0 = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_ctrl, imm_src};
  assign outs2 = {pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, result_src2,
                  alu_src_a2, alu_src_b2, alu_ctrl2, imm_src2};

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [3:0]  st;
    logic [16:0] ex;
  } vec_t;

  vec_t vecs[$];

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, alu_ctrl, imm_src}
  function automatic logic [16:0] mk(int pcw, int adr, int mw, int irw, int rw,
                                     int rs, int a, int b, int alu, int imm);
    return {pcw[0], adr[0], mw[0], irw[0], rw[0], rs[1:0], a[1:0], b[1:0], alu[2:0], imm[2:0]};
  endfunction

  task automatic add(int o, int f3, int f7, int z, int st, logic [16:0] ex);
    vec_t v;
    v.op = o[6:0]; v.f3 = f3[2:0]; v.f7 = f7[0]; v.z = z[0]; v.st = st[3:0]; v.ex = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ends at a falling edge with rst just released: cycle 0 of a fresh FETCH.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [16:0] F, DB, DJ, AWB, JALR;
  logic [3:0] exp2_st[9];
  logic       exp2_ir[9];
  logic       exp2_mw[9];

  initial begin
    F    = mk(1,0,0,1,0, 2,0,2, 0,0);
    DB   = mk(0,0,0,0,0, 0,1,1, 0,2);
    DJ   = mk(0,0,0,0,0, 0,1,1, 0,3);
    AWB  = mk(0,0,0,0,1, 0,0,0, 0,0);
    JALR = mk(1,0,0,0,0, 0,1,2, 0,0);

    // lw
    add('h03,2,0,0, 0,F); add('h03,2,0,0, 1,DB); add('h03,2,0,0, 2,mk(0,0,0,0,0,0,2,1,0,0));
    add('h03,2,0,0, 3,mk(0,1,0,0,0,0,0,0,0,0)); add('h03,2,0,0, 4,mk(0,0,0,0,1,1,0,0,0,0));
    // sw
    add('h23,2,0,0, 0,F); add('h23,2,0,0, 1,DB); add('h23,2,0,0, 2,mk(0,0,0,0,0,0,2,1,0,1));
    add('h23,2,0,0, 5,mk(0,1,1,0,0,0,0,0,0,0));
    // sub, sltu, unlisted funct3 001
    add('h33,0,1,0, 0,F); add('h33,0,1,0, 1,DB); add('h33,0,1,0, 6,mk(0,0,0,0,0,0,2,0,1,0)); add('h33,0,1,0, 8,AWB);
    add('h33,3,0,0, 0,F); add('h33,3,0,0, 1,DB); add('h33,3,0,0, 6,mk(0,0,0,0,0,0,2,0,6,0)); add('h33,3,0,0, 8,AWB);
    add('h33,1,1,0, 0,F); add('h33,1,1,0, 1,DB); add('h33,1,1,0, 6,mk(0,0,0,0,0,0,2,0,0,0)); add('h33,1,1,0, 8,AWB);
    // addi with funct7_5 set stays add; xori
    add('h13,0,1,0, 0,F); add('h13,0,1,0, 1,DB); add('h13,0,1,0, 7,mk(0,0,0,0,0,0,2,1,0,0)); add('h13,0,1,0, 8,AWB);
    add('h13,4,0,0, 0,F); add('h13,4,0,0, 1,DB); add('h13,4,0,0, 7,mk(0,0,0,0,0,0,2,1,4,0)); add('h13,4,0,0, 8,AWB);
    // beq z=1 taken, bne z=1 not, blt z=0 taken, bge z=0 not
    add('h63,0,0,1, 0,F); add('h63,0,0,1, 1,DB); add('h63,0,0,1, 9,mk(1,0,0,0,0,0,2,0,1,0));
    add('h63,1,0,1, 0,F); add('h63,1,0,1, 1,DB); add('h63,1,0,1, 9,mk(0,0,0,0,0,0,2,0,1,0));
    add('h63,4,0,0, 0,F); add('h63,4,0,0, 1,DB); add('h63,4,0,0, 9,mk(1,0,0,0,0,0,2,0,5,0));
    add('h63,5,0,0, 0,F); add('h63,5,0,0, 1,DB); add('h63,5,0,0, 9,mk(0,0,0,0,0,0,2,0,5,0));
    // jal, jalr, lui
    add('h6f,0,0,0, 0,F); add('h6f,0,0,0, 1,DJ); add('h6f,0,0,0, 10,JALR); add('h6f,0,0,0, 8,AWB);
    add('h67,0,0,0, 0,F); add('h67,0,0,0, 1,DB); add('h67,0,0,0, 11,mk(0,0,0,0,0,0,2,1,0,0));
    add('h67,0,0,0, 10,JALR); add('h67,0,0,0, 8,AWB);
    add('h37,0,0,0, 0,F); add('h37,0,0,0, 1,DB); add('h37,0,0,0, 12,mk(0,0,0,0,0,0,3,1,0,4));
    add('h37,0,0,0, 8,AWB); add('h03,2,0,0, 0,F);

    // Reset state, with inputs that would otherwise drive FETCH outputs
    @(negedge clk); #1;
    chk("reset_state0", 32'(state), 32'd0);
    chk("reset_outs0", 32'(outs0), 32'd0);
    chk("reset_state2", 32'(state2), 32'd0);
    chk("reset_outs2", 32'(outs2), 32'd0);

    // Vector table on MEM_LAT=0 instance
    do_reset();
    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      op = vecs[i].op; funct3 = vecs[i].f3; funct7_5 = vecs[i].f7; zero = vecs[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(outs0), 32'(vecs[i].ex));
    end

    // MEM_LAT=2 sw: 3-cycle FETCH, 3-cycle MEM_WRITE
    exp2_st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
    exp2_ir = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp2_mw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 7'h23; funct3 = 3'd2; funct7_5 = 1'b0; zero = 1'b0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("lat2_c%0d_state", c), 32'(state2), 32'(exp2_st[c]));
      chk($sformatf("lat2_c%0d_ir_write", c), 32'(ir_write2), 32'(exp2_ir[c]));
      chk($sformatf("lat2_c%0d_pc_write", c), 32'(pc_write2), 32'(exp2_ir[c]));
      chk($sformatf("lat2_c%0d_mem_write", c), 32'(mem_write2), 32'(exp2_mw[c]));
    end

    // Reset pulsed during EXEC_R
    op = 7'h33; funct3 = 3'd0;
    do_reset();
    @(negedge clk); @(negedge clk); #1;
    chk("rstpulse_in_exec_r", 32'(state), 32'd6);
    rst = 1'b1; #1;
    chk("rstpulse_state", 32'(state), 32'd0);
    chk("rstpulse_outs", 32'(outs0), 32'd0);
    @(negedge clk); #1;
    chk("rstpulse_hold_outs", 32'(outs0), 32'd0);
    rst = 1'b0; #1;
    chk("rstpulse_release_state", 32'(state), 32'd0);
    chk("rstpulse_release_fetch", 32'(outs0), 32'(F));
    @(negedge clk); #1;
    chk("rstpulse_after_edge", 32'(state), 32'd1);

    // Illegal opcode
    op = 7'h7f;
    do_reset();
    @(negedge clk); #1;
    chk("illegal_decode", 32'(state), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("trap_c%0d_state", c), 32'(state), 32'd13);
      chk($sformatf("trap_c%0d_illegal_op", c), 32'(illegal_op), 32'd1);
      chk($sformatf("trap_c%0d_outs", c), 32'(outs0), 32'd0);
    end
`else
    @(negedge clk); #1;
    chk("illegal_nop_state", 32'(state), 32'd0);
    chk("illegal_nop_outs", 32'(outs0), 32'(F));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
